// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Single-word CPU port in front of a block-wide L2 port.
module l1_dcache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CACHE_SIZE = 256,
  parameter int unsigned BLOCK_SIZE = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_ready,
  output logic                             cpu_hit,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
  output logic                             l2_read,
  output logic                             l2_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data,
  input  logic                             l2_block_valid,
  input  logic                             l2_ready,
  output logic [15:0]                      stat_hits,
  output logic [15:0]                      stat_misses
);

  localparam int unsigned NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int unsigned OFFSET_W  = $clog2(BLOCK_SIZE);
  localparam int unsigned INDEX_W   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W     = ADDR_WIDTH - OFFSET_W - INDEX_W;
  localparam int unsigned BLOCK_W   = BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;
  logic                    req_write_q;
  logic [NUM_LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]      data_q [NUM_LINES];

  logic [INDEX_W-1:0]      req_idx;
  logic [OFFSET_W-1:0]     req_off;
  logic [TAG_W-1:0]        req_tag;
  logic [BLOCK_W-1:0]      cur_block, wr_block;
  logic                    hit_c;

  logic [DATA_WIDTH-1:0]   cpu_rdata_d;
  logic                    cpu_ready_d, cpu_hit_d, l2_read_d, l2_write_d;
  logic [ADDR_WIDTH-1:0]   l2_addr_d;
  logic [BLOCK_W-1:0]      l2_data_out_d;
  logic [15:0]             stat_hits_d, stat_misses_d;
  logic                    latch_req, data_we, tag_we, set_valid, set_dirty, clr_dirty;

  assign req_off   = req_addr_q[OFFSET_W-1:0];
  assign req_idx   = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign cur_block = data_q[req_idx];
  assign hit_c     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Block to store: fill data on allocate, resident line on hit; stores merge their word
  always_comb begin
    wr_block = (state_q == ALLOCATE) ? l2_block_data : cur_block;
    if (req_write_q) wr_block[DATA_WIDTH*int'(req_off) +: DATA_WIDTH] = req_wdata_q;
  end

  always_comb begin
    state_d       = state_q;
    cpu_rdata_d   = cpu_rdata;
    cpu_ready_d   = 1'b0;
    cpu_hit_d     = cpu_hit;
    l2_addr_d     = l2_addr;
    l2_data_out_d = l2_data_out;
    l2_read_d     = l2_read;
    l2_write_d    = l2_write;
    stat_hits_d   = stat_hits;
    stat_misses_d = stat_misses;
    latch_req     = 1'b0;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          latch_req = 1'b1;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        if (hit_c) begin
          stat_hits_d = stat_hits + 16'd1;
          cpu_hit_d   = 1'b1;
          cpu_ready_d = 1'b1;
          state_d     = DONE;
          if (req_write_q) begin
            data_we   = 1'b1;
            set_dirty = 1'b1;
          end else begin
            cpu_rdata_d = cur_block[DATA_WIDTH*int'(req_off) +: DATA_WIDTH];
          end
        end else begin
          stat_misses_d = stat_misses + 16'd1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            l2_write_d    = 1'b1;
            l2_addr_d     = {tag_q[req_idx], req_idx, OFFSET_W'(0)};
            l2_data_out_d = cur_block;
            state_d       = WRITEBACK;
          end else begin
            l2_read_d = 1'b1;
            l2_addr_d = {req_tag, req_idx, OFFSET_W'(0)};
            state_d   = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (l2_ready) begin
          clr_dirty  = 1'b1;
          l2_write_d = 1'b0;
          l2_read_d  = 1'b1;
          l2_addr_d  = {req_tag, req_idx, OFFSET_W'(0)};
          state_d    = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (l2_ready && l2_block_valid) begin
          l2_read_d   = 1'b0;
          data_we     = 1'b1;
          tag_we      = 1'b1;
          set_valid   = 1'b1;
          set_dirty   = req_write_q;
          clr_dirty   = !req_write_q;
          cpu_hit_d   = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = DONE;
          if (!req_write_q) cpu_rdata_d = l2_block_data[DATA_WIDTH*int'(req_off) +: DATA_WIDTH];
        end
      end
      DONE: begin
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_hit     <= 1'b0;
      l2_addr     <= '0;
      l2_data_out <= '0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rdata   <= cpu_rdata_d;
      cpu_ready   <= cpu_ready_d;
      cpu_hit     <= cpu_hit_d;
      l2_addr     <= l2_addr_d;
      l2_data_out <= l2_data_out_d;
      l2_read     <= l2_read_d;
      l2_write    <= l2_write_d;
      stat_hits   <= stat_hits_d;
      stat_misses <= stat_misses_d;
      if (latch_req) begin
        req_addr_q  <= cpu_addr;
        req_wdata_q <= cpu_wdata;
        req_write_q <= cpu_write && !cpu_read;
      end
      if (set_valid) valid_q[req_idx] <= 1'b1;
      if (set_dirty)      dirty_q[req_idx] <= 1'b1;
      else if (clr_dirty) dirty_q[req_idx] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (data_we) data_q[req_idx] <= wr_block;
    if (tag_we)  tag_q[req_idx]  <= req_tag;
  end

endmodule
